// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_2r1w
// Brief    : DEPTH x DATA_W register file, two registered read ports, one
//            byte-enabled write port with same-cycle write-to-read bypass.
//            Optional macro REG_FILE_ZERO_REG_EN hardwires register 0 to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,

  input  logic                  rd0_en,
  input  logic [ADDR_W-1:0]     rd0_addr,
  output logic [DATA_W-1:0]     rd0_data,
  output logic                  rd0_valid,

  input  logic                  rd1_en,
  input  logic [ADDR_W-1:0]     rd1_addr,
  output logic [DATA_W-1:0]     rd1_data,
  output logic                  rd1_valid
);

  localparam int c_DEPTH  = 2**ADDR_W;
  localparam int c_BYTES  = DATA_W / 8;
  localparam int c_NPORTS = 2;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit c_ZERO_REG = 1'b1;
`else
  localparam bit c_ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]                r_mem [c_DEPTH];
  logic [DATA_W-1:0]                w_wr_old;
  logic [DATA_W-1:0]                w_wr_merged;
  logic                             w_wr_allow;
  logic [c_NPORTS-1:0]              w_rd_en;
  logic [c_NPORTS-1:0][ADDR_W-1:0]  w_rd_addr;

  assign w_rd_en   = {rd1_en, rd0_en};
  assign w_rd_addr = {rd1_addr, rd0_addr};

  // Merged word is shared by the storage update and both bypass paths, so a
  // bypassed read is bit-identical to what the register will hold afterwards.
  assign w_wr_old   = r_mem[wr_addr];
  assign w_wr_allow = wr_en && !(c_ZERO_REG && (wr_addr == '0));

  generate
    for (genvar gi = 0; gi < c_BYTES; gi++) begin : g_byte
      assign w_wr_merged[8*gi +: 8] = wr_be[gi] ? wr_data[8*gi +: 8]
                                                : w_wr_old[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_allow) begin
      r_mem[wr_addr] <= w_wr_merged;
    end
  end

  generate
    for (genvar gp = 0; gp < c_NPORTS; gp++) begin : g_port
      logic [DATA_W-1:0] w_value;
      logic [DATA_W-1:0] r_data;
      logic              r_valid;

      always_comb begin
        w_value = r_mem[w_rd_addr[gp]];
        if (wr_en && (wr_addr == w_rd_addr[gp])) begin
          w_value = w_wr_merged;
        end
        if (c_ZERO_REG && (w_rd_addr[gp] == '0)) begin
          w_value = '0;
        end
      end

      // Data holds when no read is requested; only valid drops.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_en[gp];
          if (w_rd_en[gp]) begin
            r_data <= w_value;
          end
        end
      end
    end
  endgenerate

  assign rd0_data  = g_port[0].r_data;
  assign rd0_valid = g_port[0].r_valid;
  assign rd1_data  = g_port[1].r_data;
  assign rd1_valid = g_port[1].r_valid;

endmodule
`default_nettype wire
